bg_scroll_ctrl: RTL and testbench
=================================

BG_SCROLL_CTRL -- requirements
Module: bg_scroll_ctrl

Interface
REQ-001 Parameter FRAMES_PER_STEP, default 256: frame ticks in RUN between speed increments (power of two, 2..1024).
REQ-002 Parameter SPEED_INIT, default 1: speed loaded on entry to RUN from IDLE or OVER.
REQ-003 Parameter SPEED_MAX, default 4: speed saturation value (SPEED_INIT <= SPEED_MAX <= 7).
REQ-004 clk  in  1  pixel clock; all flops on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 vsync  in  1  frame sync from timing generator, active-high, not assumed clk-synchronous.
REQ-007 start_btn  in  1  raw start button, active-high, asynchronous.
REQ-008 pause_btn  in  1  raw pause button, active-high, asynchronous.
REQ-009 collision  in  1  clk-synchronous collision flag from sprite logic, active-high level.
REQ-010 frame_tick  out  1  one-clk pulse per vsync rising edge.
REQ-011 scroll_x  out  10  ground/mound scroll offset in pixels, mod 1024.
REQ-012 cloud_x  out  10  cloud scroll offset, half ground rate, mod 1024.
REQ-013 star_phase  out  1  star twinkle select, toggles per frame.
REQ-014 speed  out  3  current pixels per frame.
REQ-015 state  out  2  IDLE=0, RUN=1, PAUSE=2, OVER=3.
REQ-016 render_en  out  1  high when state != IDLE; drives renderer start input.

Function
REQ-017 vsync SHALL pass a 2-flop synchronizer; frame_tick SHALL assert on the third clk after a vsync rise (fixed 3-clk latency).
REQ-018 start_btn and pause_btn SHALL each pass a 2-flop synchronizer and rising-edge detector; each press yields exactly one clk event pulse.
REQ-019 IDLE: start event -> RUN; scroll_x, cloud accumulator, frame counter cleared; speed=SPEED_INIT.
REQ-020 RUN: collision high -> OVER; else pause event -> PAUSE; collision wins when simultaneous.
REQ-021 PAUSE: pause event -> RUN; start event and collision ignored.
REQ-022 OVER: start event -> RUN with same clears as REQ-019; pause ignored.
REQ-023 State transitions SHALL take effect on the clk after the event, independent of frame_tick.
REQ-024 On frame_tick in RUN only: scroll_x <= scroll_x + speed, mod 1024 (wrap 1022+4=2).
REQ-025 Cloud accumulator (11 bit) SHALL add speed per RUN frame_tick, mod 2048; cloud_x = accumulator[10:1].
REQ-026 Frame counter SHALL count RUN frame_ticks; on reaching FRAMES_PER_STEP it resets to 0 and speed increments, saturating at SPEED_MAX.
REQ-027 star_phase SHALL toggle on every frame_tick in any state, including IDLE.
REQ-028 If a transition out of RUN and a frame_tick coincide, the scroll update for that tick SHALL still be applied (tick sampled with pre-transition state).
REQ-029 scroll_x, cloud_x, speed SHALL hold in PAUSE and OVER.

Reset
REQ-030 rst_n low: state=IDLE, scroll_x=0, cloud_x=0, accumulator=0, frame counter=0, speed=0, star_phase=0, frame_tick=0, render_en=0, all synchronizer/edge flops 0.
REQ-031 Reset asserted mid-RUN SHALL abort immediately; after release no button event fires unless a new rising edge occurs post-release.

Configuration
REQ-032 Macro BG_SCROLL_DEBOUNCE_EN defined: each button event additionally requires the synchronized level stable high for 3 consecutive frame_ticks; one event per press.
REQ-033 Macro undefined: events per REQ-018 with no debounce; debounce logic absent.

Structure
REQ-034 Shared package bg_pkg SHALL hold state encoding, SCROLL_W=10, SPEED_W=3, H_RES=1024.
REQ-035 One sub-module sync_edge (2-flop sync + rising-edge pulse) SHALL be instantiated for vsync, start_btn, pause_btn.

Verification
REQ-036 Reset, no buttons, 4 vsync pulses -> state=0, scroll_x=0, star_phase=0 after 4 toggles, render_en=0.
REQ-037 Start press, 10 vsyncs -> state=1, speed=1, scroll_x=10, cloud_x=5, frame_tick 3 clks after each vsync rise.
REQ-038 FRAMES_PER_STEP=4, RUN 20 frames -> speed 1,2,3,4,4 per 4-frame block, scroll_x=4+8+12+16+16=56.
REQ-039 scroll_x=1022, speed=4, one tick -> scroll_x=2; collision and pause same clk in RUN -> state=3.
REQ-040 Pause in RUN, 5 vsyncs -> scroll_x unchanged, star_phase toggles 5 times; second pause -> state=1.
REQ-041 rst_n low mid-RUN with start_btn held, release -> state=0 until start_btn falls and rises again.

Source files
------------

// File: rtl/bg_scroll_ctrl_pkg.sv
// Shared encodings and widths for the background scroll controller.
package bg_pkg;

  localparam int SCROLL_W = 10;
  localparam int SPEED_W  = 3;
  localparam int H_RES    = 1024;
  localparam int CLOUD_W  = SCROLL_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

endpackage

// File: rtl/bg_scroll_ctrl_sync_edge.sv
// Two-flop synchronizer with a rising-edge pulse; armed only once a
// real low level has been seen since reset, so a held input never fires.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_pulse
`ifdef BG_SCROLL_DEBOUNCE_EN
  ,
  output logic o_level
`endif
);

  logic       r_s1;
  logic       r_s2;
  logic       r_s3;
  logic       r_arm;
  logic [1:0] r_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_s3  <= 1'b0;
      r_arm <= 1'b0;
      r_vld <= 2'b00;
    end else begin
      r_s1  <= i_async;
      r_s2  <= r_s1;
      r_s3  <= r_s2;
      r_vld <= {r_vld[0], 1'b1};
      if (r_vld[1] && !r_s2)
        r_arm <= 1'b1;
    end
  end

  assign o_pulse = r_arm & r_s2 & ~r_s3;

`ifdef BG_SCROLL_DEBOUNCE_EN
  assign o_level = r_s2;
`endif

endmodule

// File: rtl/bg_scroll_ctrl.sv
// Background scroll controller: frame ticks, game state, parallax offsets.
// Optional button debounce on frame ticks via BG_SCROLL_DEBOUNCE_EN.
module bg_scroll_ctrl
  import bg_pkg::*;
#(
  parameter int FRAMES_PER_STEP = 256,
  parameter int SPEED_INIT      = 1,
  parameter int SPEED_MAX       = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                vsync,
  input  logic                start_btn,
  input  logic                pause_btn,
  input  logic                collision,
  output logic                frame_tick,
  output logic [SCROLL_W-1:0] scroll_x,
  output logic [SCROLL_W-1:0] cloud_x,
  output logic                star_phase,
  output logic [SPEED_W-1:0]  speed,
  output logic [1:0]          state,
  output logic                render_en
);

  localparam int CNT_W =
    (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(FRAMES_PER_STEP - 1);
  localparam logic [SPEED_W-1:0] SPD_INIT = SPEED_W'(SPEED_INIT);
  localparam logic [SPEED_W-1:0] SPD_MAX  = SPEED_W'(SPEED_MAX);

  logic w_vs_pulse;
  logic w_start_ev;
  logic w_pause_ev;
  logic r_tick;

`ifdef BG_SCROLL_DEBOUNCE_EN
  logic       w_vs_lvl;
  logic [1:0] w_lvl;
  logic [1:0] w_edge;
  logic [1:0] w_ev;
  logic [1:0] r_pend;
  logic [1:0] r_dcnt [2];

  sync_edge u_vs (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (vsync),
    .o_pulse (w_vs_pulse),
    .o_level (w_vs_lvl)
  );

  sync_edge u_start (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (start_btn),
    .o_pulse (w_edge[0]),
    .o_level (w_lvl[0])
  );

  sync_edge u_pause (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (pause_btn),
    .o_pulse (w_edge[1]),
    .o_level (w_lvl[1])
  );

  // a press must stay high across three frame ticks before it counts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        r_pend[i] <= 1'b0;
        r_dcnt[i] <= 2'd0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!w_lvl[i]) begin
          r_pend[i] <= 1'b0;
          r_dcnt[i] <= 2'd0;
        end else if (w_edge[i]) begin
          r_pend[i] <= 1'b1;
          r_dcnt[i] <= 2'd0;
        end else if (r_pend[i] && r_tick) begin
          if (r_dcnt[i] == 2'd2)
            r_pend[i] <= 1'b0;
          r_dcnt[i] <= r_dcnt[i] + 2'd1;
        end
      end
    end
  end

  always_comb begin
    w_ev = '0;
    for (int i = 0; i < 2; i++)
      w_ev[i] = r_pend[i] & r_tick & w_lvl[i]
              & (r_dcnt[i] == 2'd2);
  end

  assign w_start_ev = w_ev[0];
  assign w_pause_ev = w_ev[1];
`else
  sync_edge u_vs (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (vsync),
    .o_pulse (w_vs_pulse)
  );

  sync_edge u_start (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (start_btn),
    .o_pulse (w_start_ev)
  );

  sync_edge u_pause (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (pause_btn),
    .o_pulse (w_pause_ev)
  );
`endif

  state_e              r_state;
  logic [SCROLL_W-1:0] r_scroll;
  logic [CLOUD_W-1:0]  r_acc;
  logic [CNT_W-1:0]    r_cnt;
  logic [SPEED_W-1:0]  r_speed;
  logic                r_star;

  // tick update uses the pre-transition state; start clears come last
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick   <= 1'b0;
      r_state  <= ST_IDLE;
      r_scroll <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_speed  <= '0;
      r_star   <= 1'b0;
    end else begin
      r_tick <= w_vs_pulse;
      if (r_tick)
        r_star <= ~r_star;
      if (r_tick && r_state == ST_RUN) begin
        r_scroll <= r_scroll + SCROLL_W'(r_speed);
        r_acc    <= r_acc + CLOUD_W'(r_speed);
        if (r_cnt == CNT_LAST) begin
          r_cnt <= '0;
          if (r_speed < SPD_MAX)
            r_speed <= r_speed + 3'd1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
      unique case (r_state)
        ST_IDLE, ST_OVER: begin
          if (w_start_ev) begin
            r_state  <= ST_RUN;
            r_scroll <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_speed  <= SPD_INIT;
          end
        end
        ST_RUN: begin
          if (collision)
            r_state <= ST_OVER;
          else if (w_pause_ev)
            r_state <= ST_PAUSE;
        end
        ST_PAUSE: begin
          if (w_pause_ev)
            r_state <= ST_RUN;
        end
      endcase
    end
  end

  assign frame_tick = r_tick;
  assign scroll_x   = r_scroll;
  assign cloud_x    = r_acc[CLOUD_W-1:1];
  assign star_phase = r_star;
  assign speed      = r_speed;
  assign state      = r_state;
  assign render_en  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_bg_scroll_ctrl.sv
// Bench for bg_scroll_ctrl: directed table, random ops vs model, reset case.
module tb_bg_scroll_ctrl;

  localparam int FPS  = 4;
  localparam int INIT = 1;
  localparam int SMAX = 4;

  logic       clk;
  logic       rst_n;
  logic       vsync;
  logic       start_btn;
  logic       pause_btn;
  logic       collision;
  logic       frame_tick;
  logic [9:0] scroll_x;
  logic [9:0] cloud_x;
  logic       star_phase;
  logic [2:0] speed;
  logic [1:0] state;
  logic       render_en;

  bg_scroll_ctrl #(
    .FRAMES_PER_STEP (FPS),
    .SPEED_INIT      (INIT),
    .SPEED_MAX       (SMAX)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .vsync      (vsync),
    .start_btn  (start_btn),
    .pause_btn  (pause_btn),
    .collision  (collision),
    .frame_tick (frame_tick),
    .scroll_x   (scroll_x),
    .cloud_x    (cloud_x),
    .star_phase (star_phase),
    .speed      (speed),
    .state      (state),
    .render_en  (render_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {
    OP_FRAME, OP_START, OP_PAUSE, OP_COLL, OP_FCOLL, OP_PCOLL
  } op_e;

  typedef struct {
    op_e op;
    int  n;
    int  st;
    int  scr;
    int  cld;
    int  spd;
    int  star;
  } vec_t;

  vec_t tbl [17];

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: game rules in plain arithmetic
  int m_st, m_scr, m_acc, m_frames, m_spd, m_star;

  function automatic void chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  function automatic void m_reset();
    m_st = 0; m_scr = 0; m_acc = 0;
    m_frames = 0; m_spd = 0; m_star = 0;
  endfunction

  function automatic void m_tick();
    m_star = 1 - m_star;
    if (m_st == 1) begin
      m_scr = (m_scr + m_spd) % 1024;
      m_acc = (m_acc + m_spd) % 2048;
      m_frames++;
      if (m_frames == FPS) begin
        m_frames = 0;
        if (m_spd < SMAX) m_spd++;
      end
    end
  endfunction

  function automatic void m_start();
    if (m_st == 0 || m_st == 3) begin
      m_st = 1; m_scr = 0; m_acc = 0;
      m_frames = 0; m_spd = INIT;
    end
  endfunction

  function automatic void m_pause();
    if (m_st == 1) m_st = 2;
    else if (m_st == 2) m_st = 1;
  endfunction

  function automatic void m_coll();
    if (m_st == 1) m_st = 3;
  endfunction

  function automatic void check_model(string tag);
    chk({tag, ".state"}, int'(state), m_st);
    chk({tag, ".scroll"}, int'(scroll_x), m_scr);
    chk({tag, ".cloud"}, int'(cloud_x), m_acc / 2);
    chk({tag, ".speed"}, int'(speed), m_spd);
    chk({tag, ".star"}, int'(star_phase), m_star);
    chk({tag, ".render"}, int'(render_en), (m_st != 0) ? 1 : 0);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_frame(input bit coll);
    int ticks;
    int at;
    ticks = 0;
    at = 0;
    vsync = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      if (frame_tick) begin
        ticks++;
        at = k;
      end
      if (k == 3) begin
        m_tick();
        if (coll) begin
          collision = 1'b1;
          m_coll();
        end
      end
      if (k == 4) begin
        collision = 1'b0;
        vsync = 1'b0;
      end
    end
    chk("tick_latency", at, 3);
    chk("tick_count", ticks, 1);
  endtask

  task automatic press(input bit is_start, input bit coll);
    if (is_start) start_btn = 1'b1;
    else pause_btn = 1'b1;
    step();
    step();
    if (coll) collision = 1'b1;
    step();
    collision = 1'b0;
    if (coll && m_st == 1) m_coll();
    else if (is_start) m_start();
    else m_pause();
    step();
    start_btn = 1'b0;
    pause_btn = 1'b0;
    repeat (3) step();
  endtask

  task automatic collide();
    collision = 1'b1;
    step();
    collision = 1'b0;
    m_coll();
    step();
  endtask

  task automatic run_op(input op_e op);
    case (op)
      OP_FRAME: do_frame(1'b0);
      OP_START: press(1'b1, 1'b0);
      OP_PAUSE: press(1'b0, 1'b0);
      OP_COLL:  collide();
      OP_FCOLL: do_frame(1'b1);
      default:  press(1'b0, 1'b1);
    endcase
  endtask

  initial begin
    tbl[0]  = '{OP_FRAME,   4, 0,    0,   0, 0, 0};
    tbl[1]  = '{OP_START,   1, 1,    0,   0, 1, 0};
    tbl[2]  = '{OP_FRAME,  20, 1,   56,  28, 4, 0};
    tbl[3]  = '{OP_PAUSE,   1, 2,   56,  28, 4, 0};
    tbl[4]  = '{OP_FRAME,   5, 2,   56,  28, 4, 1};
    tbl[5]  = '{OP_PAUSE,   1, 1,   56,  28, 4, 1};
    tbl[6]  = '{OP_FRAME,   1, 1,   60,  30, 4, 0};
    tbl[7]  = '{OP_COLL,    1, 3,   60,  30, 4, 0};
    tbl[8]  = '{OP_PAUSE,   1, 3,   60,  30, 4, 0};
    tbl[9]  = '{OP_FRAME,   2, 3,   60,  30, 4, 0};
    tbl[10] = '{OP_START,   1, 1,    0,   0, 1, 0};
    tbl[11] = '{OP_FRAME,  10, 1,   18,   9, 3, 0};
    tbl[12] = '{OP_FRAME, 251, 1, 1020, 510, 4, 1};
    tbl[13] = '{OP_FRAME,   1, 1,    0, 512, 4, 0};
    tbl[14] = '{OP_FCOLL,   1, 3,    4, 514, 4, 1};
    tbl[15] = '{OP_START,   1, 1,    0,   0, 1, 1};
    tbl[16] = '{OP_PCOLL,   1, 3,    0,   0, 1, 1};

    rst_n = 1'b0;
    vsync = 1'b0;
    start_btn = 1'b0;
    pause_btn = 1'b0;
    collision = 1'b0;
    m_reset();
    repeat (3) step();
    chk("rst.tick", int'(frame_tick), 0);
    check_model("rst");
    rst_n = 1'b1;
    repeat (4) step();

    for (int i = 0; i < 17; i++) begin
      for (int r = 0; r < tbl[i].n; r++)
        run_op(tbl[i].op);
      chk($sformatf("row%0d.state", i), int'(state), tbl[i].st);
      chk($sformatf("row%0d.scroll", i), int'(scroll_x), tbl[i].scr);
      chk($sformatf("row%0d.cloud", i), int'(cloud_x), tbl[i].cld);
      chk($sformatf("row%0d.speed", i), int'(speed), tbl[i].spd);
      chk($sformatf("row%0d.star", i), int'(star_phase), tbl[i].star);
      chk($sformatf("row%0d.render", i), int'(render_en),
          (tbl[i].st != 0) ? 1 : 0);
    end

    for (int i = 0; i < 250; i++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel < 5) run_op(OP_FRAME);
      else if (sel == 5) run_op(OP_START);
      else if (sel == 6) run_op(OP_PAUSE);
      else if (sel == 7) run_op(OP_COLL);
      else if (sel == 8) run_op(OP_FCOLL);
      else run_op(OP_PCOLL);
      check_model($sformatf("rnd%0d", i));
    end

    if (m_st == 0 || m_st == 3) run_op(OP_START);
    else if (m_st == 2) run_op(OP_PAUSE);
    repeat (3) run_op(OP_FRAME);
    check_model("pre_abort");
    start_btn = 1'b1;
    repeat (2) step();
    rst_n = 1'b0;
    m_reset();
    step();
    check_model("abort");
    chk("abort.tick", int'(frame_tick), 0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (10) step();
    check_model("held_start");
    start_btn = 1'b0;
    repeat (4) step();
    check_model("released");
    run_op(OP_START);
    chk("restart.state", int'(state), 1);
    check_model("restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
